// File: rtl/nic_responder_if.sv
// nic_responder_if
//   Groups the processor-side NIC access signals and the router-port
//   ready/valid handshake into one bundle.
//   slave  : the NIC (nic_responder) side.
//   master : the processor memory stage / router side.
//   Processor: nicEn, nicEnWr, adder_nic, d_in -> NIC; d_out <- NIC.
//   Router in : net_si, net_di -> NIC; net_ri <- NIC.
//   Router out: net_ro, net_polarity -> NIC; net_so, net_do <- NIC.
interface nic_responder_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  nicEn;
    logic                  nicEnWr;
    logic [1:0]            adder_nic;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;

    modport slave (
        input  nicEn, nicEnWr, adder_nic, d_in,
        input  net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output nicEn, nicEnWr, adder_nic, d_in,
        output net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_responder.sv
// nic_responder
//   Processor-side NIC. One 64-bit input-channel buffer (router -> processor)
//   and one 64-bit output-channel buffer (processor -> router), each with a
//   full flag. The processor reaches them through memory-mapped registers:
//     adder_nic 00 input buffer, 01 input status, 10 output buffer, 11 output status.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, clears buffers and flags
//     bus   : nic_responder_if.slave (processor access + router handshake)
module nic_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    nic_responder_if.slave   bus
);
    localparam logic [1:0] A_IN_BUF  = 2'b00;
    localparam logic [1:0] A_IN_STAT = 2'b01;
    localparam logic [1:0] A_OUT_BUF = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;

    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_full;
    logic                  out_full;

    logic ld, st;
    logic in_push, in_pop, out_push, out_pop;

    assign ld = bus.nicEn & ~bus.nicEnWr;
    assign st = bus.nicEn &  bus.nicEnWr;

    // Push and pop on each channel are mutually exclusive by construction:
    // push needs the flag clear, pop needs it set.
    assign in_push  = bus.net_si & ~in_full;
    assign in_pop   = ld & (bus.adder_nic == A_IN_BUF) & in_full;
    assign out_push = st & (bus.adder_nic == A_OUT_BUF) & ~out_full;
    assign out_pop  = bus.net_so;

    // Router handshake. A packet only goes out when its VC bit matches the
    // router's current polarity; otherwise it is retried every cycle.
    assign bus.net_ri = ~in_full;
    assign bus.net_do = out_buf;
    assign bus.net_so = out_full & bus.net_ro & (bus.net_polarity == out_buf[VC_BIT]);

    always_comb begin
        bus.d_out = '0;
        if (ld) begin
            case (bus.adder_nic)
                A_IN_BUF:   bus.d_out = in_buf;  // stale if empty; software polls status first
                A_IN_STAT:  bus.d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                A_OUT_STAT: bus.d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:    bus.d_out = '0;
            endcase
        end
    end

    // Input channel. in_buf is retained after a read so a repeated load of
    // the buffer register returns the last packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else begin
            if (in_push) begin
                in_buf  <= bus.net_di;
                in_full <= 1'b1;
            end else if (in_pop) begin
                in_full <= 1'b0;
            end
        end
    end

    // Output channel. A store while full is silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else begin
            if (out_push) begin
                out_buf  <= bus.d_in;
                out_full <= 1'b1;
            end else if (out_pop) begin
                out_full <= 1'b0;
            end
        end
    end

    // Register-select constant kept for readability of the decode above.
    logic unused_ok;
    assign unused_ok = &{1'b0, A_OUT_BUF};
endmodule

// File: tb/tb_nic_responder.sv
module tb_nic_responder;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nic_responder_if #(.DATA_WIDTH(DW)) bus();

    nic_responder #(.DATA_WIDTH(DW), .VC_BIT(63)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          en;
        logic          wr;
        logic [1:0]    addr;
        logic [DW-1:0] d_in;
        logic          si;
        logic [DW-1:0] di;
        logic          ro;
        logic          pol;
        logic [DW-1:0] e_dout;
        logic          e_ri;
        logic          e_so;
        logic [DW-1:0] e_do;
    } vec_t;

    vec_t tbl[$];
    int n_chk = 0;
    int n_fail = 0;

    // reference model: each channel is a capacity-one queue
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] in_last;
    logic [DW-1:0] out_last;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] addr,
                                input logic [DW-1:0] d_in, input logic si, input logic [DW-1:0] di,
                                input logic ro, input logic pol, input logic [DW-1:0] e_dout,
                                input logic e_ri, input logic e_so, input logic [DW-1:0] e_do);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.d_in = d_in; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.e_dout = e_dout; v.e_ri = e_ri; v.e_so = e_so; v.e_do = e_do;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.nicEn        = v.en;
        bus.nicEnWr      = v.wr;
        bus.adder_nic    = v.addr;
        bus.d_in         = v.d_in;
        bus.net_si       = v.si;
        bus.net_di       = v.di;
        bus.net_ro       = v.ro;
        bus.net_polarity = v.pol;
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        in_last  = '0;
        out_last = '0;
    endtask

    // Expected outputs from the register map and handshake rules.
    task automatic model_expect(input vec_t v, output vec_t e);
        e = v;
        e.e_ri = (in_q.size() == 0);
        e.e_do = out_last;
        e.e_so = (out_q.size() != 0) && v.ro && (v.pol == out_last[63]);
        e.e_dout = '0;
        if (v.en && !v.wr) begin
            case (v.addr)
                2'b00: e.e_dout = in_last;
                2'b01: e.e_dout = DW'(in_q.size());
                2'b11: e.e_dout = DW'(out_q.size());
                default: e.e_dout = '0;
            endcase
        end
    endtask

    task automatic model_step(input vec_t v, input logic so);
        bit in_had, out_had;
        in_had  = (in_q.size() != 0);
        out_had = (out_q.size() != 0);
        if (v.en && !v.wr && v.addr == 2'b00 && in_had) void'(in_q.pop_front());
        else if (v.si && !in_had) begin
            in_q.push_back(v.di);
            in_last = v.di;
        end
        if (so) void'(out_q.pop_front());
        else if (v.en && v.wr && v.addr == 2'b10 && !out_had) begin
            out_q.push_back(v.d_in);
            out_last = v.d_in;
        end
    endtask

    initial begin
        vec_t v, e;
        logic [DW-1:0] pa, pb, pc;
        pa = 64'hA5A5_0000_1234_5678;
        pb = 64'h8000_0000_0000_00FF;
        pc = 64'h0000_0000_0000_CAFE;

        // en wr addr d_in si di ro pol | d_out ri so do
        tbl.push_back(mk(0,0,2'b00,0,0,0,0,0,   0,1,0,0));
        tbl.push_back(mk(1,0,2'b01,0,0,0,0,0,   0,1,0,0));
        tbl.push_back(mk(1,0,2'b11,0,0,0,0,0,   0,1,0,0));
        tbl.push_back(mk(0,0,2'b00,0,1,pa,0,0,  0,1,0,0));
        tbl.push_back(mk(1,0,2'b01,0,0,0,0,0,   1,0,0,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,   pa,0,0,0));
        tbl.push_back(mk(1,0,2'b01,0,0,0,0,0,   0,1,0,0));
        tbl.push_back(mk(1,1,2'b10,pb,0,0,1,0,  0,1,0,0));
        tbl.push_back(mk(0,0,2'b00,0,0,0,1,0,   0,1,0,pb));
        tbl.push_back(mk(1,0,2'b11,0,0,0,1,0,   1,1,0,pb));
        tbl.push_back(mk(0,0,2'b00,0,0,0,1,1,   0,1,1,pb));
        tbl.push_back(mk(1,0,2'b11,0,0,0,1,1,   0,1,0,pb));
        tbl.push_back(mk(1,1,2'b10,64'h5,0,0,0,0, 0,1,0,pb));
        tbl.push_back(mk(1,1,2'b10,64'h1,0,0,0,0, 0,1,0,64'h5));
        tbl.push_back(mk(0,0,2'b00,0,0,0,1,0,   0,1,1,64'h5));
        tbl.push_back(mk(1,0,2'b11,0,0,0,1,0,   0,1,0,64'h5));
        tbl.push_back(mk(0,0,2'b00,0,1,pc,0,0,  0,1,0,64'h5));
        tbl.push_back(mk(1,0,2'b00,0,1,64'hBEEF,0,0, pc,0,0,64'h5));
        tbl.push_back(mk(1,0,2'b01,0,1,64'hBEEF,0,0, 0,1,0,64'h5));
        tbl.push_back(mk(1,0,2'b01,0,0,0,0,0,   1,0,0,64'h5));
        tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,   64'hBEEF,0,0,64'h5));
        tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,   64'hBEEF,1,0,64'h5));
        tbl.push_back(mk(1,0,2'b10,0,0,0,0,0,   0,1,0,64'h5));
        tbl.push_back(mk(1,1,2'b00,64'h123,0,0,0,0, 0,1,0,64'h5));
        tbl.push_back(mk(1,1,2'b01,64'h1,0,0,0,0,   0,1,0,64'h5));
        tbl.push_back(mk(1,1,2'b11,64'h1,0,0,0,0,   0,1,0,64'h5));
        tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,   64'hBEEF,1,0,64'h5));
        tbl.push_back(mk(1,0,2'b01,0,0,0,0,0,   0,1,0,64'h5));
        tbl.push_back(mk(0,1,2'b10,64'h7,0,0,0,0, 0,1,0,64'h5));
        tbl.push_back(mk(1,0,2'b11,0,0,0,0,0,   0,1,0,64'h5));

        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ri", {63'b0, bus.net_ri}, 1);
        chk("reset_so", {63'b0, bus.net_so}, 0);
        chk("reset_do", bus.net_do, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d_dout", i), bus.d_out, tbl[i].e_dout);
            chk($sformatf("vec%0d_ri", i), {63'b0, bus.net_ri}, {63'b0, tbl[i].e_ri});
            chk($sformatf("vec%0d_so", i), {63'b0, bus.net_so}, {63'b0, tbl[i].e_so});
            chk($sformatf("vec%0d_do", i), bus.net_do, tbl[i].e_do);
        end

        // randomized phase against the queue model
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            v.en   = ($urandom_range(0, 3) != 0);
            v.wr   = $urandom_range(0, 1);
            v.addr = 2'($urandom_range(0, 3));
            v.d_in = {$urandom, $urandom};
            v.si   = $urandom_range(0, 1);
            v.di   = {$urandom, $urandom};
            v.ro   = ($urandom_range(0, 3) != 0);
            v.pol  = $urandom_range(0, 1);
            drive(v);
            #1;
            model_expect(v, e);
            chk($sformatf("rnd%0d_dout", i), bus.d_out, e.e_dout);
            chk($sformatf("rnd%0d_ri", i), {63'b0, bus.net_ri}, {63'b0, e.e_ri});
            chk($sformatf("rnd%0d_so", i), {63'b0, bus.net_so}, {63'b0, e.e_so});
            chk($sformatf("rnd%0d_do", i), bus.net_do, e.e_do);
            model_step(v, e.e_so);
        end

        // asynchronous reset with both channels full
        @(negedge clk);
        drive(mk(1,1,2'b10,64'h8000_0000_0000_0042,1,64'h77,0,0,0,0,0,0));
        @(negedge clk);
        drive(mk(1,1,2'b10,64'h8000_0000_0000_0042,1,64'h77,0,0,0,0,0,0));
        @(negedge clk);
        drive(mk(1,0,2'b11,0,0,0,1,0,0,0,0,0));
        #1;
        chk("pre_rst_ri", {63'b0, bus.net_ri}, 0);
        chk("pre_rst_outstat", bus.d_out, 1);
        chk("pre_rst_so", {63'b0, bus.net_so}, 0);
        bus.net_polarity = 1'b1;
        #1;
        chk("pre_rst_so_match", {63'b0, bus.net_so}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ri", {63'b0, bus.net_ri}, 1);
        chk("async_rst_so", {63'b0, bus.net_so}, 0);
        chk("async_rst_outstat", bus.d_out, 0);
        chk("async_rst_do", bus.net_do, 0);
        bus.adder_nic = 2'b01;
        #1;
        chk("async_rst_instat", bus.d_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1,0,2'b00,0,0,0,0,0,0,0,0,0));
        #1;
        chk("post_rst_inbuf", bus.d_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
